// File: rtl/clk_gate_ctrl.sv
// Divided-clock generator with per-channel sleep/wake gating.
// Each channel drains for a programmable number of div_clk periods before its gate closes.
module clk_gate_ctrl #(
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned DIV_WIDTH     = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned DRAIN_PERIODS = 1
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  input  logic [DIV_WIDTH-1:0] div_sel,
  input  logic [NUM_CH-1:0]    sleep_req,
  input  logic [NUM_CH-1:0]    wake,
  output logic                 div_clk,
  output logic [NUM_CH-1:0]    gclk,
  output logic [NUM_CH-1:0]    ch_on,
  output logic [NUM_CH-1:0]    sleep_ack
);

  typedef enum logic [1:0] {StRun, StPend, StSleep, StWake} ch_state_e;

  localparam logic [3:0] DrainInit = 4'(DRAIN_PERIODS);

  // Divider
  logic [DIV_WIDTH-1:0] count_q, count_d;
  logic [DIV_WIDTH-1:0] div_lat_q, div_lat_d;
  logic                 div_clk_q, div_clk_d;
  logic                 period_end;
  logic                 fall_tick;

  always_comb begin
    period_end = (count_q == div_lat_q);
    fall_tick  = period_end & div_clk_q;
    count_d    = period_end ? '0 : count_q + 1'b1;
    div_clk_d  = div_clk_q ^ period_end;
    // Only reload the half-period at a falling edge so no phase gets truncated.
    div_lat_d  = fall_tick ? div_sel : div_lat_q;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      count_q   <= '0;
      div_lat_q <= '0;
      div_clk_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      div_lat_q <= div_lat_d;
      div_clk_q <= div_clk_d;
    end
  end

  assign div_clk = div_clk_q;

  // Wake synchroniser and pending latch
  logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q;
  logic [NUM_CH-1:0]                  wake_s;
  logic [NUM_CH-1:0]                  wake_pend_q, wake_pend_d;
  logic [NUM_CH-1:0]                  wake_eff;

  always_comb begin
    wake_s      = sync_q[SYNC_STAGES-1];
    wake_eff    = wake_s | wake_pend_q;
    // Holds a short wake pulse until the next falling edge consumes it.
    wake_pend_d = fall_tick ? '0 : (wake_pend_q | wake_s);
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      sync_q      <= '0;
      wake_pend_q <= '0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], wake};
      wake_pend_q <= wake_pend_d;
    end
  end

  // Per-channel control
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_state_e  state_q, state_d;
    logic [3:0] drain_q, drain_d;
    logic       ch_on_q, ch_on_d;
    logic       ack_q;

    always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      if (fall_tick) begin
        case (state_q)
          StRun: begin
            if (sleep_req[i] && !wake_eff[i]) begin
              state_d = StPend;
              drain_d = DrainInit;
            end
          end
          StPend: begin
            if (wake_eff[i] || !sleep_req[i]) begin
              state_d = StRun;
            end else begin
              drain_d = drain_q - 1'b1;
              if (drain_q == 4'd1) state_d = StSleep;
            end
          end
          StSleep: begin
            if (wake_eff[i] || !sleep_req[i]) state_d = StWake;
          end
          StWake:  state_d = StRun;
          default: state_d = StRun;
        endcase
      end
      // Enable only moves at the start of a low phase, keeping the gated clock glitch-free.
      ch_on_d = fall_tick ? (state_d != StSleep) : ch_on_q;
    end

    always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
        state_q <= StRun;
        drain_q <= '0;
        ch_on_q <= 1'b0;
        ack_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        drain_q <= drain_d;
        ch_on_q <= ch_on_d;
        ack_q   <= (state_d == StSleep);
      end
    end

    assign ch_on[i]     = ch_on_q;
    assign sleep_ack[i] = ack_q;

    ClockGate u_clock_gate (
      .CLK  (div_clk_q),
      .en   (ch_on_q),
      .GCLK (gclk[i])
    );
  end

endmodule

// Latch-based integrated clock gate: enable is captured while CLK is low.
module ClockGate (
  input  logic CLK,
  input  logic en,
  output logic GCLK
);

  logic en_lat;

  always_latch begin
    if (!CLK) en_lat = en;
  end

  assign GCLK = CLK & en_lat;

endmodule
